rgb_fade_pwm: RTL and testbench

Downstream output stage for the RGB mixer's three 8-bit encoder level registers.
- Slews each channel's level toward its target at a programmable rate.
- Latches the resulting duty glitch-free at the PWM period boundary.
- Drives three PWM outputs and a period-start strobe.

---
 rtl/rgb_fade_pkg.sv | 40 ++++
 rtl/rgb_fade_channel.sv | 62 ++++++
 rtl/rgb_fade_pwm.sv | 91 +++++++++
 tb/tb_rgb_fade_pwm.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fade_pkg.sv
// Shared constants for the RGB fade/PWM output stage.
// Defining RGB_FADE_GAMMA_EN adds the gamma-2.2 duty table.
package rgb_fade_pkg;

  localparam int RGB_WIDTH = 8;
  localparam logic [RGB_WIDTH-1:0] PWM_MAX = {RGB_WIDTH{1'b1}};

`ifdef RGB_FADE_GAMMA_EN
  typedef logic [255:0][7:0] gamma_lut_t;

  // Entry i = round(255 * (i/255)^2.2), formed as i^2 * (i/255)^0.2 with a 16-bit fixed-point fifth root.
  function automatic gamma_lut_t gamma_build();
    gamma_lut_t   lut;
    logic [127:0] root;
    logic [127:0] cand;
    logic [127:0] lhs;
    logic [127:0] rhs;
    logic [127:0] num;
    for (int i = 0; i < 256; i++) begin
      root = 128'd0;
      rhs  = 128'(i) << 80;
      for (int b = 16; b >= 0; b--) begin
        cand = root | (128'd1 << b);
        lhs  = cand * cand * cand * cand * cand * 128'd255;
        if (lhs <= rhs) begin
          root = cand;
        end else begin
          root = root;
        end
      end
      num    = 128'(i) * 128'(i) * root + 128'd8355840;
      lut[i] = 8'(num / 128'd16711680);
    end
    return lut;
  endfunction

  localparam gamma_lut_t GAMMA_LUT = gamma_build();
`endif

endpackage

// File: rtl/rgb_fade_channel.sv
// One colour channel: target register, +/-1 level slew, period-aligned duty shadow, PWM compare.
// With RGB_FADE_GAMMA_EN the duty shadow loads the gamma-corrected level.
module rgb_fade_channel
  import rgb_fade_pkg::*;
#(
  parameter int WIDTH = RGB_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_tick,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_cnt,
  output logic             o_pwm,
  output logic             o_differs
);

  localparam logic [WIDTH-1:0] LVL_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_tgt_q;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] w_level_next;
  logic [WIDTH-1:0] w_duty_src;

  // Slew one step toward the registered target; saturation is implicit since equality holds.
  always_comb begin
    w_level_next = r_level;
    if (!i_tick) begin
      w_level_next = r_level;
    end else if (r_level < r_tgt_q) begin
      w_level_next = r_level + LVL_ONE;
    end else if (r_level > r_tgt_q) begin
      w_level_next = r_level - LVL_ONE;
    end else begin
      w_level_next = r_level;
    end
  end

`ifdef RGB_FADE_GAMMA_EN
  assign w_duty_src = WIDTH'(GAMMA_LUT[r_level]);
`else
  assign w_duty_src = r_level;
`endif

  // Duty captures the pre-tick level so a load and a step in one cycle never mix.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tgt_q <= {WIDTH{1'b0}};
      r_level <= {WIDTH{1'b0}};
      r_duty  <= {WIDTH{1'b0}};
    end else begin
      r_tgt_q <= i_target;
      r_level <= w_level_next;
      r_duty  <= i_load ? w_duty_src : r_duty;
    end
  end

  assign o_pwm     = (i_cnt < r_duty);
  assign o_differs = (r_level != r_tgt_q);

endmodule

// File: rtl/rgb_fade_pwm.sv
// RGB fade/PWM output stage: shared period counter and step prescaler driving three channels.
// Optional gamma duty mapping is enabled with RGB_FADE_GAMMA_EN.
module rgb_fade_pwm
  import rgb_fade_pkg::*;
#(
  parameter int WIDTH      = RGB_WIDTH,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      target0,
  input  logic [WIDTH-1:0]      target1,
  input  logic [WIDTH-1:0]      target2,
  input  logic [PRESCALE_W-1:0] step_div,
  output logic                  pwm0_out,
  output logic                  pwm1_out,
  output logic                  pwm2_out,
  output logic                  fading,
  output logic                  period_start
);

  localparam logic [WIDTH-1:0]      CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  logic [WIDTH-1:0]      r_cnt;
  logic [PRESCALE_W-1:0] r_pre;
  logic                  r_fading;
  logic                  r_period_start;
  logic                  w_tick;
  logic                  w_at_max;
  logic                  w_differs0;
  logic                  w_differs1;
  logic                  w_differs2;

  // A step_div lowered below the running count ticks immediately via >=.
  assign w_tick   = (r_pre >= step_div);
  assign w_at_max = (r_cnt == CNT_MAX);

  // Free-running period counter, step prescaler and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= {WIDTH{1'b0}};
      r_pre          <= {PRESCALE_W{1'b0}};
      r_fading       <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= r_cnt + CNT_ONE;
      r_pre          <= w_tick ? {PRESCALE_W{1'b0}} : r_pre + PRE_ONE;
      r_fading       <= w_differs0 | w_differs1 | w_differs2;
      r_period_start <= w_at_max;
    end
  end

  rgb_fade_channel #(.WIDTH(WIDTH)) u_ch0 (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_target  (target0),
    .i_tick    (w_tick),
    .i_load    (w_at_max),
    .i_cnt     (r_cnt),
    .o_pwm     (pwm0_out),
    .o_differs (w_differs0)
  );

  rgb_fade_channel #(.WIDTH(WIDTH)) u_ch1 (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_target  (target1),
    .i_tick    (w_tick),
    .i_load    (w_at_max),
    .i_cnt     (r_cnt),
    .o_pwm     (pwm1_out),
    .o_differs (w_differs1)
  );

  rgb_fade_channel #(.WIDTH(WIDTH)) u_ch2 (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_target  (target2),
    .i_tick    (w_tick),
    .i_load    (w_at_max),
    .i_cnt     (r_cnt),
    .o_pwm     (pwm2_out),
    .o_differs (w_differs2)
  );

  assign fading       = r_fading;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Directed bench for rgb_fade_pwm: reset, ramp timing, saturation, mid-period target change,
// reset mid-ramp, and (with RGB_FADE_GAMMA_EN) gamma-mapped duty.
module tb_rgb_fade_pwm;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  target0;
  logic [7:0]  target1;
  logic [7:0]  target2;
  logic [15:0] step_div;
  logic        pwm0_out;
  logic        pwm1_out;
  logic        pwm2_out;
  logic        fading;
  logic        period_start;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;

  int exp_lvl [6] = '{0, 1, 2, 3, 4, 4};
  int exp_fad [6] = '{0, 1, 1, 1, 1, 0};

  always #5 clk = ~clk;

  rgb_fade_pwm #(.WIDTH(8), .PRESCALE_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .target0      (target0),
    .target1      (target1),
    .target2      (target2),
    .step_div     (step_div),
    .pwm0_out     (pwm0_out),
    .pwm1_out     (pwm1_out),
    .pwm2_out     (pwm2_out),
    .fading       (fading),
    .period_start (period_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; samples land on the falling edge, cyc mod 256 is the expected cnt.
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic align();
    tick_n(1);
    while (cyc % 256 != 0) tick_n(1);
  endtask

  function automatic logic pwm_sel(input int ch);
    case (ch)
      0:       return pwm0_out;
      1:       return pwm1_out;
      default: return pwm2_out;
    endcase
  endfunction

  // Sample one full period starting at cnt == 0: pwm must be high exactly for cnt < duty.
  task automatic check_period(input int ch, input int duty, input string tag);
    int   hi;
    int   bad;
    logic p;
    logic e;
    hi  = 0;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      p = pwm_sel(ch);
      e = (k < duty);
      if (p === 1'b1) hi++;
      if (p !== e) bad++;
      tick_n(1);
    end
    chk({tag, "_high_cycles"}, hi, duty);
    chk({tag, "_shape"}, bad, 0);
  endtask

  initial begin
    int first_ps;
    int quiet_bad;
    int hi;
    int bad;
    logic p;

    // 1: reset and first period
    reset    = 1'b1;
    target0  = 8'd0;
    target1  = 8'd0;
    target2  = 8'd0;
    step_div = 16'd0;
    repeat (5) @(negedge clk);
    chk("rst_pwm", {pwm2_out, pwm1_out, pwm0_out}, 3'b000);
    chk("rst_fading", fading, 1'b0);
    chk("rst_period_start", period_start, 1'b0);
    chk("rst_cnt", dut.r_cnt, 8'd0);
    reset     = 1'b0;
    cyc       = 0;
    first_ps  = -1;
    quiet_bad = 0;
    for (int n = 1; n <= 300; n++) begin
      tick_n(1);
      if (period_start === 1'b1) begin
        first_ps = n;
        break;
      end
      if ((pwm0_out | pwm1_out | pwm2_out | fading) !== 1'b0) quiet_bad++;
    end
    chk("first_period_start", first_ps, 256);
    chk("quiet_first_period", quiet_bad, 0);

    // 2: fast ramp of channel 0 to 4
    target0 = 8'd4;
    for (int n = 0; n < 6; n++) begin
      tick_n(1);
      chk($sformatf("ramp0_level_%0d", n + 1), dut.u_ch0.r_level, exp_lvl[n]);
      chk($sformatf("ramp0_fading_%0d", n + 1), fading, exp_fad[n]);
    end
    align();
    chk("duty0_is_4", dut.u_ch0.r_duty, 8'd4);
    check_period(0, 4, "pwm0_duty4");

    // 3: slow ramp of channel 1 up to saturation and back to 0
    step_div = 16'd9;
    target1  = 8'd255;
    tick_n(9);
    chk("slow_lvl1_9", dut.u_ch1.r_level, 8'd0);
    tick_n(1);
    chk("slow_lvl1_10", dut.u_ch1.r_level, 8'd1);
    tick_n(9);
    chk("slow_lvl1_19", dut.u_ch1.r_level, 8'd1);
    tick_n(1);
    chk("slow_lvl1_20", dut.u_ch1.r_level, 8'd2);
    tick_n(2529);
    chk("slow_lvl1_2549", dut.u_ch1.r_level, 8'd254);
    chk("slow_fading_2549", fading, 1'b1);
    tick_n(1);
    chk("slow_lvl1_2550", dut.u_ch1.r_level, 8'd255);
    tick_n(10);
    chk("slow_lvl1_sat", dut.u_ch1.r_level, 8'd255);
    chk("slow_fading_settled", fading, 1'b0);
    align();
    check_period(1, 255, "pwm1_full");
    target1 = 8'd0;
    tick_n(2600);
    chk("slow_lvl1_down", dut.u_ch1.r_level, 8'd0);
    align();
    check_period(1, 0, "pwm1_zero");

    // 4: channel 2 target changes 10 -> 200 at cnt 50
    step_div = 16'd0;
    target2  = 8'd10;
    tick_n(20);
    align();
    chk("duty2_is_10", dut.u_ch2.r_duty, 8'd10);
    hi  = 0;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      p = pwm2_out;
      if (p === 1'b1) hi++;
      if (p !== 1'(k < 10)) bad++;
      if (k == 50) target2 = 8'd200;
      if (k == 100) chk("midperiod_lvl2", dut.u_ch2.r_level, 8'd59);
      tick_n(1);
    end
    chk("pwm2_old_period_high", hi, 10);
    chk("pwm2_old_period_shape", bad, 0);
    chk("duty2_is_200", dut.u_ch2.r_duty, 8'd200);
    check_period(2, 200, "pwm2_new");

    // 5: reset mid-ramp at level0 = 100
    target0 = 8'd255;
    tick_n(97);
    chk("pre_rst_lvl0", dut.u_ch0.r_level, 8'd100);
    chk("pre_rst_fading", fading, 1'b1);
    chk("pre_rst_duty0", dut.u_ch0.r_duty, 8'd4);
    reset = 1'b1;
    tick_n(1);
    chk("mid_rst_lvl0", dut.u_ch0.r_level, 8'd0);
    chk("mid_rst_duty", {dut.u_ch0.r_duty, dut.u_ch1.r_duty, dut.u_ch2.r_duty}, 24'd0);
    chk("mid_rst_cnt", dut.r_cnt, 8'd0);
    chk("mid_rst_fading", fading, 1'b0);
    chk("mid_rst_period_start", period_start, 1'b0);
    chk("mid_rst_pwm", {pwm2_out, pwm1_out, pwm0_out}, 3'b000);
    reset   = 1'b0;
    cyc     = 0;
    target0 = 8'd0;
    target1 = 8'd0;
    target2 = 8'd0;

`ifdef RGB_FADE_GAMMA_EN
    // 6: gamma-mapped duty
    target0 = 8'd128;
    tick_n(140);
    align();
    chk("gamma_duty0_128", dut.u_ch0.r_duty, 8'd56);
    check_period(0, 56, "gamma_pwm0_128");
    target0 = 8'd255;
    tick_n(140);
    align();
    check_period(0, 255, "gamma_pwm0_255");
    target0 = 8'd0;
    tick_n(260);
    align();
    check_period(0, 0, "gamma_pwm0_0");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
